// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester, ROM and status signals shared by the arbiter and its environment.
interface rom_arbiter_if;
  logic [23:0] ROM_MASK;
  logic        CPU_REQ;
  logic [23:0] CPU_ADDR;
  logic        CPU_WORD;
  logic        CPU_ACK;
  logic [15:0] CPU_Q;
  logic        COP_REQ;
  logic [23:0] COP_ADDR;
  logic        COP_WORD;
  logic        COP_ACK;
  logic [15:0] COP_Q;
  logic [23:0] MEM_ADDR;
  logic        MEM_CE_N;
  logic        MEM_OE_N;
  logic        MEM_WORD;
  logic [15:0] MEM_Q;
  logic        BUSY;
  modport master (
    output ROM_MASK, CPU_REQ, CPU_ADDR, CPU_WORD, COP_REQ, COP_ADDR, COP_WORD, MEM_Q,
    input  CPU_ACK, CPU_Q, COP_ACK, COP_Q, MEM_ADDR, MEM_CE_N, MEM_OE_N, MEM_WORD, BUSY
  );
  modport slave (
    input  ROM_MASK, CPU_REQ, CPU_ADDR, CPU_WORD, COP_REQ, COP_ADDR, COP_WORD, MEM_Q,
    output CPU_ACK, CPU_Q, COP_ACK, COP_Q, MEM_ADDR, MEM_CE_N, MEM_OE_N, MEM_WORD, BUSY
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one ROM between CPU and coprocessor with alternating priority on contention.
module rom_arbiter #(
  parameter int unsigned RD_LAT = 3
) (
  input logic         MCLK,
  input logic         RESET_N,
  rom_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_cop_q, last_cop_d;
  logic        sel_cop_q, sel_cop_d;
  logic        lsb_q, lsb_d;
  logic [23:0] addr_q, addr_d;
  logic        word_q, word_d;
  logic        ce_n_q, ce_n_d;
  logic [15:0] cpu_q_q, cpu_q_d, cop_q_q, cop_q_d, cap;
  logic        cpu_ack_q, cpu_ack_d, cop_ack_q, cop_ack_d;
  logic        gnt_cop;
  always_comb begin
    gnt_cop    = bus.COP_REQ && (!bus.CPU_REQ || !last_cop_q);
    cap        = word_q ? bus.MEM_Q : {8'h00, lsb_q ? bus.MEM_Q[15:8] : bus.MEM_Q[7:0]};
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_cop_d = last_cop_q;
    sel_cop_d  = sel_cop_q;
    lsb_d      = lsb_q;
    addr_d     = addr_q;
    word_d     = word_q;
    ce_n_d     = ce_n_q;
    cpu_q_d    = cpu_q_q;
    cop_q_d    = cop_q_q;
    cpu_ack_d  = 1'b0;
    cop_ack_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.CPU_REQ || bus.COP_REQ) begin
        state_d    = ACCESS;
        cnt_d      = 4'(RD_LAT - 1);
        sel_cop_d  = gnt_cop;
        last_cop_d = gnt_cop;
        addr_d     = (gnt_cop ? bus.COP_ADDR : bus.CPU_ADDR) & bus.ROM_MASK;
        word_d     = gnt_cop ? bus.COP_WORD : bus.CPU_WORD;
        lsb_d      = gnt_cop ? bus.COP_ADDR[0] : bus.CPU_ADDR[0];
        ce_n_d     = 1'b0;
      end
      ACCESS: if (cnt_q == 4'd0) begin
        state_d   = DONE;
        ce_n_d    = 1'b1;
        cpu_ack_d = !sel_cop_q;
        cop_ack_d = sel_cop_q;
        cpu_q_d   = sel_cop_q ? cpu_q_q : cap;
        cop_q_d   = sel_cop_q ? cap : cop_q_q;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_cop_q <= 1'b1;
      sel_cop_q  <= 1'b0;
      lsb_q      <= 1'b0;
      addr_q     <= 24'd0;
      word_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      cpu_q_q    <= 16'd0;
      cop_q_q    <= 16'd0;
      cpu_ack_q  <= 1'b0;
      cop_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_cop_q <= last_cop_d;
      sel_cop_q  <= sel_cop_d;
      lsb_q      <= lsb_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      ce_n_q     <= ce_n_d;
      cpu_q_q    <= cpu_q_d;
      cop_q_q    <= cop_q_d;
      cpu_ack_q  <= cpu_ack_d;
      cop_ack_q  <= cop_ack_d;
    end
  end
  assign bus.MEM_ADDR = addr_q;
  assign bus.MEM_WORD = word_q;
  assign bus.MEM_CE_N = ce_n_q;
  assign bus.MEM_OE_N = ce_n_q;
  assign bus.CPU_Q    = cpu_q_q;
  assign bus.COP_Q    = cop_q_q;
  assign bus.CPU_ACK  = cpu_ack_q;
  assign bus.COP_ACK  = cop_ack_q;
  assign bus.BUSY     = state_q != IDLE;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed checks of two arbiters, RD_LAT=3 (bus a) and RD_LAT=1 (bus b).
module tb_rom_arbiter;
  logic mclk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;
  rom_arbiter_if a ();
  rom_arbiter_if b ();
  rom_arbiter #(.RD_LAT(3)) dut3 (.MCLK(mclk), .RESET_N(reset_n), .bus(a.slave));
  rom_arbiter #(.RD_LAT(1)) dut1 (.MCLK(mclk), .RESET_N(reset_n), .bus(b.slave));
  always #5 mclk = ~mclk;
  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    a.ROM_MASK = 24'hFFFFFF; a.MEM_Q = 16'h0000;
    a.CPU_REQ = 0; a.CPU_ADDR = 0; a.CPU_WORD = 0;
    a.COP_REQ = 0; a.COP_ADDR = 0; a.COP_WORD = 0;
    b.ROM_MASK = 24'hFFFFFF; b.MEM_Q = 16'h0000;
    b.CPU_REQ = 0; b.CPU_ADDR = 0; b.CPU_WORD = 0;
    b.COP_REQ = 0; b.COP_ADDR = 0; b.COP_WORD = 0;
    step(2);
    chk("rst_ce_n", 32'(a.MEM_CE_N), 32'h1);
    chk("rst_oe_n", 32'(a.MEM_OE_N), 32'h1);
    chk("rst_busy", 32'(a.BUSY), 32'h0);
    chk("rst_addr", 32'(a.MEM_ADDR), 32'h0);
    chk("rst_word", 32'(a.MEM_WORD), 32'h0);
    chk("rst_acks", 32'({a.CPU_ACK, a.COP_ACK}), 32'h0);
    chk("rst_qs", 32'({a.CPU_Q, a.COP_Q}), 32'h0);
    reset_n = 1'b1;
    step(1);
    // byte read from odd address picks the high byte
    a.CPU_REQ = 1; a.CPU_ADDR = 24'h008001; a.CPU_WORD = 0; a.MEM_Q = 16'hBEEF;
    step(1);
    chk("b_addr", 32'(a.MEM_ADDR), 32'h008001);
    chk("b_ce_n", 32'(a.MEM_CE_N), 32'h0);
    chk("b_oe_n", 32'(a.MEM_OE_N), 32'h0);
    chk("b_busy", 32'(a.BUSY), 32'h1);
    step(2);
    chk("b_noack3", 32'(a.CPU_ACK), 32'h0);
    step(1);
    chk("b_ack4", 32'(a.CPU_ACK), 32'h1);
    chk("b_cop_ack4", 32'(a.COP_ACK), 32'h0);
    chk("b_q", 32'(a.CPU_Q), 32'h00BE);
    chk("b_ce_off", 32'(a.MEM_CE_N), 32'h1);
    chk("b_busy_done", 32'(a.BUSY), 32'h1);
    a.CPU_REQ = 0;
    step(1);
    chk("b_ack5", 32'(a.CPU_ACK), 32'h0);
    chk("b_idle", 32'(a.BUSY), 32'h0);
    // request withdrawn and address changed mid-access
    a.CPU_REQ = 1; a.CPU_ADDR = 24'h000010; a.CPU_WORD = 0; a.MEM_Q = 16'h5A3C;
    step(1);
    chk("d_addr", 32'(a.MEM_ADDR), 32'h000010);
    a.CPU_REQ = 0; a.CPU_ADDR = 24'h123456; a.CPU_WORD = 1;
    step(1);
    chk("d_addr_hold", 32'(a.MEM_ADDR), 32'h000010);
    chk("d_word_hold", 32'(a.MEM_WORD), 32'h0);
    step(2);
    chk("d_ack", 32'(a.CPU_ACK), 32'h1);
    chk("d_q", 32'(a.CPU_Q), 32'h003C);
    step(1);
    chk("d_idle", 32'(a.BUSY), 32'h0);
    // masked coprocessor word read
    a.ROM_MASK = 24'h0FFFFF; a.COP_REQ = 1; a.COP_ADDR = 24'hFFFFFF; a.COP_WORD = 1;
    a.MEM_Q = 16'h1234;
    step(1);
    chk("m_addr", 32'(a.MEM_ADDR), 32'h0FFFFF);
    chk("m_word", 32'(a.MEM_WORD), 32'h1);
    step(3);
    chk("m_ack", 32'(a.COP_ACK), 32'h1);
    chk("m_cpu_ack", 32'(a.CPU_ACK), 32'h0);
    chk("m_q", 32'(a.COP_Q), 32'h1234);
    chk("m_cpu_q", 32'(a.CPU_Q), 32'h003C);
    a.COP_REQ = 0;
    step(1);
    // both requesting continuously: last grant was COP, so CPU leads
    a.ROM_MASK = 24'hFFFFFF;
    a.CPU_ADDR = 24'h000100; a.CPU_WORD = 1;
    a.COP_ADDR = 24'h000200; a.COP_WORD = 1;
    a.CPU_REQ = 1; a.COP_REQ = 1; a.MEM_Q = 16'h7788;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("f_addr", 32'(a.MEM_ADDR), (i % 2 == 1) ? 32'h000200 : 32'h000100);
      step(3);
      chk("f_cpu_ack", 32'(a.CPU_ACK), (i % 2 == 1) ? 32'h0 : 32'h1);
      chk("f_cop_ack", 32'(a.COP_ACK), (i % 2 == 1) ? 32'h1 : 32'h0);
      step(1);
      chk("f_gap", 32'({a.CPU_ACK, a.COP_ACK, a.BUSY}), 32'h0);
    end
    a.CPU_REQ = 0; a.COP_REQ = 0;
    step(1);
    // reset during the second access cycle aborts without ACK
    a.CPU_REQ = 1; a.CPU_ADDR = 24'h000ABC; a.CPU_WORD = 1; a.MEM_Q = 16'h9999;
    step(1);
    chk("r_busy", 32'(a.BUSY), 32'h1);
    step(1);
    #2 reset_n = 1'b0;
    #1;
    chk("r_ce_n", 32'(a.MEM_CE_N), 32'h1);
    chk("r_busy0", 32'(a.BUSY), 32'h0);
    chk("r_q0", 32'(a.CPU_Q), 32'h0);
    step(2);
    chk("r_noack", 32'(a.CPU_ACK), 32'h0);
    reset_n = 1'b1;
    step(1);
    chk("r_regrant", 32'(a.MEM_CE_N), 32'h0);
    chk("r_addr", 32'(a.MEM_ADDR), 32'h000ABC);
    step(3);
    chk("r_ack", 32'(a.CPU_ACK), 32'h1);
    chk("r_q", 32'(a.CPU_Q), 32'h9999);
    a.CPU_REQ = 0;
    // RD_LAT=1 back to back: one access every three cycles
    b.CPU_REQ = 1; b.CPU_ADDR = 24'h000002; b.CPU_WORD = 1; b.MEM_Q = 16'hCAFE;
    step(1);
    chk("l1_busy", 32'(b.BUSY), 32'h1);
    chk("l1_noack", 32'(b.CPU_ACK), 32'h0);
    step(1);
    chk("l1_ack2", 32'(b.CPU_ACK), 32'h1);
    chk("l1_q", 32'(b.CPU_Q), 32'h00CAFE);
    step(1);
    chk("l1_idle3", 32'({b.CPU_ACK, b.BUSY}), 32'h0);
    b.MEM_Q = 16'h0102;
    step(1);
    chk("l1_regrant4", 32'(b.BUSY), 32'h1);
    step(1);
    chk("l1_ack5", 32'(b.CPU_ACK), 32'h1);
    chk("l1_q2", 32'(b.CPU_Q), 32'h0102);
    chk("l1_a_quiet", 32'(a.BUSY), 32'h0);
    b.CPU_REQ = 0;
    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
